// File: rtl/riscv_mc_controller_if.sv
// ============================================================================
// riscv_mc_controller_if
// Control/status bundle between the multicycle controller and its datapath.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_mc_controller_if;
    logic [6:0] op_code;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [3:0] state_o;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  op_code, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               state_o, trap, trap_cause
    );

    modport slave (
        output op_code, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               state_o, trap, trap_cause
    );
endinterface

`default_nettype wire

// File: rtl/riscv_mc_controller.sv
// ============================================================================
// riscv_mc_controller
// Multicycle RV32I main control FSM with memory-ready timeout and sticky trap.
// Optional feature macro: MC_CTRL_JAL_EN (builds the JAL state).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mc_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    riscv_mc_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    logic       mem_wait;
    logic       timeout;

    // Only the three memory-handshake states can stall on mem_ready.
    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);
    assign timeout  = (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        wait_d  = 8'd0;
        trap_d  = trap_q;
        cause_d = cause_q;

        if (mem_wait && !bus.mem_ready)
            wait_d = wait_q + 8'd1;

        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)
                    state_d = S_DECODE;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                case (bus.op_code)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:            state_d = S_JAL;
`endif
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR:
                state_d = (bus.op_code == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (bus.mem_ready)
                    state_d = S_MEMWB;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready)
                    state_d = S_FETCH;
                else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
`ifdef MC_CTRL_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase

        if (state_d == S_TRAP)
            trap_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Moore decode of the registered state; only FETCH/BEQ strobes see inputs.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.reg_write  = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            S_MEMREAD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b11;
            end
            S_EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b11;
            end
            S_ALUWB:    bus.reg_write = 1'b1;
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.pc_write  = bus.zero;
            end
`ifdef MC_CTRL_JAL_EN
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (bus.op_code)
            OP_STORE:  bus.imm_src = 2'b01;
            OP_BRANCH: bus.imm_src = 2'b10;
            OP_JAL:    bus.imm_src = 2'b11;
            default:   bus.imm_src = 2'b00;
        endcase
    end

    assign bus.state_o    = state_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mc_controller.sv
// ============================================================================
// tb_riscv_mc_controller
// Scoreboard bench: stimulus pushes expected outputs, a monitor compares them.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mc_controller;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] ILL  = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       adr;
        logic       mw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] imm;
        logic       rw;
        logic       trap;
        logic [1:0] cause;
    } vec_t;

    typedef struct {
        vec_t  v;
        string name;
    } item_t;

    logic clk;
    logic rst;
    item_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    riscv_mc_controller_if bus ();

    riscv_mc_controller #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Expected output vector for a given state, taken from the state table.
    function automatic vec_t model(input logic [3:0] st, input logic [6:0] opc,
                                   input logic rdy, input logic z,
                                   input logic [1:0] cause);
        vec_t e;
        e = '0;
        e.st    = st;
        e.trap  = (st == 4'd11);
        e.cause = cause;
        e.imm   = (opc == SW) ? 2'b01 : (opc == BEQ) ? 2'b10 :
                  (opc == JAL) ? 2'b11 : 2'b00;
        case (st)
            4'd0:  begin e.b = 2'b10; e.rs = 2'b10; e.pcw = rdy; e.irw = rdy; end
            4'd1:  begin e.a = 2'b01; e.b = 2'b01; end
            4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
            4'd3:  e.adr = 1'b1;
            4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            4'd6:  begin e.a = 2'b10; e.op = 2'b11; end
            4'd7:  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b11; end
            4'd8:  e.rw = 1'b1;
            4'd9:  begin e.a = 2'b10; e.op = 2'b01; e.pcw = z; end
            4'd10: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one cycle's inputs, record what the DUT must show, advance a cycle.
    task automatic step(input logic [3:0] st, input logic [6:0] opc,
                        input logic rdy, input logic z,
                        input logic [1:0] cause, input string name);
        item_t it;
        bus.op_code   = opc;
        bus.mem_ready = rdy;
        bus.zero      = z;
        it.v    = model(st, opc, rdy, z, cause);
        it.name = name;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [6:0] opc, input logic rdy, input string name);
        rst = 1'b1;
        step(4'd0, opc, rdy, 1'b0, 2'b00, name);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            vec_t  act;
            it  = sb.pop_front();
            act = '{st: bus.state_o, pcw: bus.pc_write, irw: bus.ir_write,
                    adr: bus.adr_src, mw: bus.mem_write, rs: bus.result_src,
                    a: bus.alu_src_a, b: bus.alu_src_b, op: bus.alu_op,
                    imm: bus.imm_src, rw: bus.reg_write, trap: bus.trap,
                    cause: bus.trap_cause};
            n_checks++;
            if (act !== it.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", it.name, act, it.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.op_code   = 7'd0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        #1;
        apply_reset(7'd0, 1'b0, "reset_state");

        step(4'd0, ADD, 1, 0, 2'b00, "add_fetch");
        step(4'd1, ADD, 1, 0, 2'b00, "add_decode");
        step(4'd6, ADD, 1, 0, 2'b00, "add_execr");
        step(4'd8, ADD, 1, 0, 2'b00, "add_aluwb");

        step(4'd0, ADD, 1, 0, 2'b00, "rst_fetch");
        step(4'd1, ADD, 1, 0, 2'b00, "rst_decode");
        apply_reset(ADD, 1'b1, "rst_mid_execr");
        step(4'd0, ADD, 1, 0, 2'b00, "rst_after_fetch");
        step(4'd1, ADD, 1, 0, 2'b00, "rst_after_decode");
        step(4'd6, ADD, 1, 0, 2'b00, "rst_after_execr");
        step(4'd8, ADD, 1, 0, 2'b00, "rst_after_aluwb");

        step(4'd0, ADDI, 1, 0, 2'b00, "addi_fetch");
        step(4'd1, ADDI, 1, 0, 2'b00, "addi_decode");
        step(4'd7, ADDI, 1, 0, 2'b00, "addi_execi");
        step(4'd8, ADDI, 1, 0, 2'b00, "addi_aluwb");

        step(4'd0, LW, 1, 0, 2'b00, "lw_fetch");
        step(4'd1, LW, 1, 0, 2'b00, "lw_decode");
        step(4'd2, LW, 1, 0, 2'b00, "lw_memadr");
        step(4'd3, LW, 0, 0, 2'b00, "lw_memread_wait1");
        step(4'd3, LW, 0, 0, 2'b00, "lw_memread_wait2");
        step(4'd3, LW, 1, 0, 2'b00, "lw_memread_done");
        step(4'd4, LW, 1, 0, 2'b00, "lw_memwb");

        step(4'd0, SW, 1, 0, 2'b00, "sw_fetch");
        step(4'd1, SW, 1, 0, 2'b00, "sw_decode");
        step(4'd2, SW, 1, 0, 2'b00, "sw_memadr");
        step(4'd5, SW, 0, 0, 2'b00, "sw_memwrite_wait");
        step(4'd5, SW, 1, 0, 2'b00, "sw_memwrite_done");

        step(4'd0, BEQ, 1, 1, 2'b00, "beq1_fetch");
        step(4'd1, BEQ, 1, 1, 2'b00, "beq1_decode");
        step(4'd9, BEQ, 1, 1, 2'b00, "beq_taken");
        step(4'd0, BEQ, 1, 0, 2'b00, "beq0_fetch");
        step(4'd1, BEQ, 1, 0, 2'b00, "beq0_decode");
        step(4'd9, BEQ, 1, 0, 2'b00, "beq_not_taken");

        // Wait ends exactly at the bound with mem_ready high: no trap.
        step(4'd0, ADD, 0, 0, 2'b00, "bound_wait0");
        step(4'd0, ADD, 0, 0, 2'b00, "bound_wait1");
        step(4'd0, ADD, 0, 0, 2'b00, "bound_wait2");
        step(4'd0, ADD, 1, 0, 2'b00, "bound_ready_at_last");
        step(4'd1, ADD, 1, 0, 2'b00, "bound_decode");
        step(4'd6, ADD, 1, 0, 2'b00, "bound_execr");
        step(4'd8, ADD, 1, 0, 2'b00, "bound_aluwb");

        step(4'd0, JAL, 1, 0, 2'b00, "jal_fetch");
        step(4'd1, JAL, 1, 0, 2'b00, "jal_decode");
`ifdef MC_CTRL_JAL_EN
        step(4'd10, JAL, 1, 0, 2'b00, "jal_state");
        step(4'd8,  JAL, 1, 0, 2'b00, "jal_aluwb");
`else
        step(4'd11, JAL, 1, 0, 2'b01, "jal_disabled_trap");
        apply_reset(JAL, 1'b1, "jal_disabled_reset");
`endif

        step(4'd0,  ILL, 1, 0, 2'b00, "ill_fetch");
        step(4'd1,  ILL, 1, 0, 2'b00, "ill_decode");
        step(4'd11, ILL, 1, 0, 2'b01, "ill_trap");
        step(4'd11, ADD, 0, 1, 2'b01, "ill_trap_hold1");
        step(4'd11, LW,  1, 0, 2'b01, "ill_trap_hold2");
        apply_reset(ADD, 1'b0, "ill_reset_clears");

        step(4'd0,  ADD, 0, 0, 2'b00, "to_wait0");
        step(4'd0,  ADD, 0, 0, 2'b00, "to_wait1");
        step(4'd0,  ADD, 0, 0, 2'b00, "to_wait2");
        step(4'd0,  ADD, 0, 0, 2'b00, "to_wait3");
        step(4'd11, ADD, 0, 0, 2'b10, "to_trap");
        step(4'd11, ADD, 1, 0, 2'b10, "to_trap_hold");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

- Multicycle main control FSM for the RV32I core.
- Sequences the shared ALU, register file, PC and unified instruction/data memory port over several cycles per instruction.
- Drives the 2-bit `alu_op` consumed by the ALU decoder (00 add, 01 sub, 11 funct-decoded).
- Paces memory accesses with a ready handshake, bounded by a timeout.

## Interface
- `TIMEOUT`, 16: consecutive `mem_ready=0` cycles tolerated in a memory-wait state before trapping; legal range 1..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op_code` in 7: `instr[6:0]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register enable.
- `result_src` out 2: result mux select; 00 ALU-out register, 01 read data, 10 ALU result.
- `alu_src_a` out 2: ALU A select; 00 PC, 01 old PC, 10 rs1.
- `alu_src_b` out 2: ALU B select; 00 rs2, 01 immediate, 10 constant 4.
- `alu_op` out 2: to ALU decoder.
- `imm_src` out 2: immediate format; 00 I, 01 S, 10 B, 11 J.
- `reg_write` out 1: register file write enable.
- `state_o` out 4: current state encoding, for debug.
- `trap` out 1: sticky trap flag.
- `trap_cause` out 2: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.

Per-state outputs (Moore, except where gated; any output not listed is 0):
- **FETCH**
  - Outputs: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10; `ir_write`=`pc_write`=`mem_ready`.
  - Transition: DECODE when `mem_ready`.
- **DECODE**
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch target).
  - Dispatch on `op_code`:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL (see Configuration)
    - anything else -> TRAP, cause 01
- **MEMADR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - Transition: MEMREAD if `op_code`=0000011, else MEMWRITE.
- **MEMREAD**
  - Outputs: `adr_src`=1, `result_src`=00.
  - Transition: MEMWB when `mem_ready`.
- **MEMWB**
  - Outputs: `result_src`=01, `reg_write`=1.
  - Transition: FETCH.
- **MEMWRITE**
  - Outputs: `adr_src`=1, `result_src`=00; `mem_write`=1, held every cycle until `mem_ready`.
  - Transition: FETCH when `mem_ready`.
- **EXECR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=11.
  - Transition: ALUWB.
- **EXECI**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11.
  - Transition: ALUWB.
- **ALUWB**
  - Outputs: `result_src`=00, `reg_write`=1.
  - Transition: FETCH.
- **BEQ**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00; `pc_write`=`zero`.
  - Transition: FETCH.
- **JAL**
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1.
  - Transition: ALUWB.
- **TRAP**
  - Outputs: all control outputs 0, `trap`=1.
  - Transition: none; remains here until `rst`.

Other rules:
- `imm_src` is combinational from `op_code` in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- Wait counter (8-bit):
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle spent in one of those states with `mem_ready`=0.
  - If `mem_ready`=0 while the counter equals `TIMEOUT`-1, next state is TRAP with cause 10.
  - `mem_ready`=1 on that same cycle takes priority: normal transition, no trap.
- `trap_cause` is latched on entry to TRAP and held.

## Timing
- Reset (async assert): state=FETCH, wait counter=0, `trap`=0, `trap_cause`=00.
  - All outputs take their FETCH values; `pc_write`/`ir_write` follow `mem_ready`.
  - On `rst` assertion mid-instruction, state is abandoned immediately and no writes complete.
- Cycle counts per instruction with `mem_ready` always 1:
  - R-type / I-type ALU: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - jal: 4
- Each `mem_ready`=0 cycle in a memory-wait state adds exactly one cycle.
- Wait bound: at most `TIMEOUT` consecutive wait cycles, then TRAP on the following edge.
- `pc_write` and `ir_write` in FETCH, and `pc_write` in BEQ, are combinational on `mem_ready`/`zero`; no added latency.

## Configuration
- `MC_CTRL_JAL_EN` defined:
  - DECODE dispatches 1101111 to JAL.
  - JAL writes PC+4 to rd via ALUWB; the PC takes the target computed in DECODE.
- `MC_CTRL_JAL_EN` undefined:
  - JAL state is not built.
  - 1101111 is illegal and goes to TRAP with cause 01.
  - `imm_src` still decodes 11 for that opcode.

## Test plan
- **Reset:** assert `rst` mid-EXECR -> `state_o`=0 that cycle, `reg_write`=0, `trap`=0; after release, FETCH proceeds when `mem_ready`=1.
- **add:** `op_code`=0110011, `mem_ready`=1 -> `state_o` 0,1,6,8,0; `alu_op`=11 in EXECR; `reg_write`=1 only in ALUWB.
- **lw with wait:** `op_code`=0000011, `mem_ready` low for 2 cycles in MEMREAD -> 7 total cycles; `adr_src`=1 throughout MEMREAD; `result_src`=01 in MEMWB.
- **beq:** `zero`=1 -> `pc_write`=1 in BEQ with `alu_op`=01; `zero`=0 -> `pc_write`=0.
- **Illegal opcode:** `op_code`=1111111 -> TRAP, `trap_cause`=01, held until `rst`.
- **Timeout:** `TIMEOUT`=4 with `mem_ready`=0 in FETCH -> TRAP after 4 wait cycles, cause 10.
- **jal:** with the macro, 1101111 -> `state_o` 0,1,10,8,0; without it -> TRAP, cause 01.
